// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// ALU operation classes and the raw per-state control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Ungated control word; memacc marks states whose strobes wait on memready.
    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       instret;
        logic       memacc;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] opc);
        return (opc == OP_LW) || (opc == OP_SW) || (opc == OP_RTYPE) ||
               (opc == OP_BEQ) || (opc == OP_ADDI) || (opc == OP_J);
    endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational state -> control word decode for the multicycle controller.
module mc_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  cw
);

    always_comb begin
        cw = '0;
        unique case (state)
            S_FETCH: begin
                cw.memacc  = 1'b1;
                cw.irwrite = 1'b1;
                cw.pcwrite = 1'b1;
                cw.alusrcb = 2'b01;
                cw.aluop   = ALUOP_ADD;
            end
            S_DECODE: begin
                cw.alusrcb = 2'b11;
                cw.aluop   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = 2'b10;
                cw.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                cw.memacc = 1'b1;
                cw.iord   = 1'b1;
            end
            S_MEMWB: begin
                cw.memtoreg = 1'b1;
                cw.regwrite = 1'b1;
                cw.instret  = 1'b1;
            end
            S_MEMWR: begin
                cw.memacc   = 1'b1;
                cw.iord     = 1'b1;
                cw.memwrite = 1'b1;
                cw.instret  = 1'b1;
            end
            S_RTYPEEX: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = 2'b00;
                cw.aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                cw.regdst   = 1'b1;
                cw.regwrite = 1'b1;
                cw.instret  = 1'b1;
            end
            S_BEQEX: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = 2'b00;
                cw.aluop   = ALUOP_SUB;
                cw.pcsrc   = 2'b01;
                cw.branch  = 1'b1;
                cw.instret = 1'b1;
            end
            S_ADDIWB: begin
                cw.regwrite = 1'b1;
                cw.instret  = 1'b1;
            end
            S_JEX: begin
                cw.pcsrc   = 2'b10;
                cw.pcwrite = 1'b1;
                cw.instret = 1'b1;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS main control FSM: state register, next-state logic and
// gating of strobes by memready, zero and reset.
module multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       memready,
    output logic       pcen,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       instret,
    output logic       illegal
);

    state_t state, nstate;
    ctrl_t  cw;
    logic   strobe_ok;
    logic   bad_op;

    mc_outdec u_outdec (
        .state (state),
        .cw    (cw)
    );

    always_comb begin
        nstate = S_FETCH;
        unique case (state)
            S_FETCH:   nstate = memready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW) nstate = S_MEMADR;
                else if (op == OP_RTYPE)        nstate = S_RTYPEEX;
                else if (op == OP_BEQ)          nstate = S_BEQEX;
                else if (op == OP_ADDI)         nstate = S_ADDIEX;
                else if (op == OP_J)            nstate = S_JEX;
                else                            nstate = S_FETCH;
            end
            S_MEMADR:  nstate = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   nstate = memready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   nstate = memready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: nstate = S_RTYPEWB;
            S_ADDIEX:  nstate = S_ADDIWB;
            default:   nstate = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= nstate;
    end

    // Reset masks strobes combinationally so a pending write drops mid-cycle.
    assign strobe_ok = ~reset & (~cw.memacc | memready);
    assign bad_op    = ~reset & (state == S_DECODE) & ~op_supported(op);

    assign pcen     = strobe_ok & (cw.pcwrite | (cw.branch & zero));
    assign irwrite  = strobe_ok & cw.irwrite;
    assign memwrite = strobe_ok & cw.memwrite;
    assign regwrite = strobe_ok & cw.regwrite;
    assign instret  = (strobe_ok & cw.instret) | bad_op;
    assign illegal  = bad_op;

    assign iord     = cw.iord;
    assign memtoreg = cw.memtoreg;
    assign regdst   = cw.regdst;
    assign alusrca  = cw.alusrca;
    assign alusrcb  = cw.alusrcb;
    assign aluop    = cw.aluop;
    assign pcsrc    = cw.pcsrc;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: per-instruction cycle sequences are expanded from the
// instruction timing rules and compared cycle by cycle against the controller.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset, zero, memready;
    logic [5:0] op;
    logic       pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       instret, illegal;

    typedef struct packed {
        logic       pcen;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       instret;
        logic       illegal;
    } cw_t;

    cw_t         act;
    cw_t         expq[$];
    int unsigned total = 0;
    int unsigned bad   = 0;

    multicycle_controller dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .zero     (zero),
        .memready (memready),
        .pcen     (pcen),
        .irwrite  (irwrite),
        .memwrite (memwrite),
        .regwrite (regwrite),
        .iord     (iord),
        .memtoreg (memtoreg),
        .regdst   (regdst),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .aluop    (aluop),
        .pcsrc    (pcsrc),
        .instret  (instret),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    assign act = {pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
                  alusrcb, aluop, pcsrc, instret, illegal};

    task automatic check(input string nm, input cw_t a, input cw_t e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, a, e);
        end
    endtask

    always @(negedge clk) begin : monitor
        cw_t e;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            check("cw", act, e);
        end
    end

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic bit known(input logic [5:0] o);
        return o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
               o == 6'b000100 || o == 6'b001000 || o == 6'b000010;
    endfunction

    function automatic cw_t fetch_sel();
        cw_t c = '0;
        c.alusrcb = 2'b01;
        return c;
    endfunction

    task automatic step(input logic r, input logic mr, input logic z,
                        input logic [5:0] o, input cw_t e);
        @(posedge clk);
        #1;
        reset    = r;
        memready = mr;
        zero     = z;
        op       = o;
        expq.push_back(e);
    endtask

    task automatic run_instr(input logic [5:0] o, input int unsigned fst,
                             input int unsigned mst, input logic zb, input bit abort);
        cw_t e;
        for (int unsigned i = 0; i < fst; i++) step(1'b0, 1'b0, rb(), o, fetch_sel());
        e = fetch_sel(); e.irwrite = 1'b1; e.pcen = 1'b1;
        step(1'b0, 1'b1, rb(), o, e);
        e = '0; e.alusrcb = 2'b11;
        if (!known(o)) begin
            e.illegal = 1'b1; e.instret = 1'b1;
            step(1'b0, rb(), rb(), o, e);
            return;
        end
        step(1'b0, rb(), rb(), o, e);
        case (o)
            6'b100011, 6'b101011: begin
                e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
                step(1'b0, rb(), rb(), o, e);
                e = '0; e.iord = 1'b1;
                for (int unsigned i = 0; i < mst; i++) step(1'b0, 1'b0, rb(), o, e);
                if (o == 6'b100011) begin
                    step(1'b0, 1'b1, rb(), o, e);
                    e = '0; e.memtoreg = 1'b1; e.regwrite = 1'b1; e.instret = 1'b1;
                    step(1'b0, rb(), rb(), o, e);
                end else begin
                    e.memwrite = 1'b1; e.instret = 1'b1;
                    step(1'b0, 1'b1, rb(), o, e);
                end
            end
            6'b000000: begin
                e = '0; e.alusrca = 1'b1; e.aluop = 2'b10;
                step(1'b0, rb(), rb(), o, e);
                e = '0; e.regdst = 1'b1; e.regwrite = 1'b1; e.instret = 1'b1;
                step(1'b0, rb(), rb(), o, e);
                if (abort) begin
                    // Mid-cycle reset, after the WB word has been sampled.
                    #6;
                    reset = 1'b1;
                    #1;
                    check("rst_async", act, fetch_sel());
                    step(1'b1, 1'b1, rb(), o, fetch_sel());
                end
            end
            6'b000100: begin
                e = '0; e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsrc = 2'b01;
                e.instret = 1'b1; e.pcen = zb;
                step(1'b0, rb(), zb, o, e);
            end
            6'b001000: begin
                e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
                step(1'b0, rb(), rb(), o, e);
                e = '0; e.regwrite = 1'b1; e.instret = 1'b1;
                step(1'b0, rb(), rb(), o, e);
            end
            default: begin
                e = '0; e.pcsrc = 2'b10; e.pcen = 1'b1; e.instret = 1'b1;
                step(1'b0, rb(), rb(), o, e);
            end
        endcase
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] o;
        ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000;
        ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000010;
        reset = 1'b1; memready = 1'b1; zero = 1'b0; op = 6'b000000;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 6'b000000, fetch_sel());
        run_instr(6'b000000, 0, 0, 1'b0, 1'b0);
        run_instr(6'b100011, 0, 2, 1'b0, 1'b0);
        run_instr(6'b000100, 0, 0, 1'b1, 1'b0);
        run_instr(6'b000100, 0, 0, 1'b0, 1'b0);
        run_instr(6'b101011, 0, 1, 1'b0, 1'b0);
        run_instr(6'b111111, 0, 0, 1'b0, 1'b0);
        run_instr(6'b000010, 1, 0, 1'b0, 1'b0);
        run_instr(6'b000000, 0, 0, 1'b0, 1'b1);

        for (int n = 0; n < 200; n++) begin
            int unsigned k = $urandom_range(0, 7);
            if (k < 6) o = ops[k];
            else       o = 6'($urandom_range(0, 63));
            run_instr(o, $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0,
                      $urandom_range(0, 2) == 0 ? $urandom_range(1, 3) : 0,
                      rb(), $urandom_range(0, 15) == 0);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
